// File: rtl/gemm_out_drain.sv
// gemm_out_drain
//   Drains the GEMM array's result vectors. Each element is requantized
//   (rounding arithmetic right shift, then signed saturation), whole vectors
//   are buffered in a small FIFO, and the head vector is serialized one
//   element per cycle onto a valid/ready stream.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   one-cycle pulse, in_data holds a result vector
//   in_data    N signed elements of DATA_WIDTH_IN
//   cfg_shift  requant right-shift amount, sampled with in_valid
//   in_ready   FIFO not full (informational, the array never stalls)
//   m_valid    output element valid
//   m_ready    sink accepts the element
//   m_data     current element, signed DATA_WIDTH_OUT
//   m_index    element index within its vector
//   m_last     high on the final element of a vector
//   overflow   sticky, set when a vector is dropped
//   drop_cnt   saturating count of dropped vectors
//
// Build option
//   GEMM_OUT_DRAIN_RELU_EN : when defined, negative saturated results become 0.
//
// Serializer states
//   state | meaning
//   IDLE  | FIFO empty, nothing presented
//   SEND  | head vector element idx presented on the stream

module gemm_out_drain #(
    parameter int N              = 4,
    parameter int DATA_WIDTH_IN  = 16,
    parameter int DATA_WIDTH_OUT = 8,
    parameter int DEPTH          = 4,
    parameter int SHIFT_W        = 4,
    localparam int IDX_W         = (N > 1) ? $clog2(N) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic signed [DATA_WIDTH_IN-1:0]  in_data [N],
    input  logic        [SHIFT_W-1:0]        cfg_shift,
    output logic                             in_ready,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic signed [DATA_WIDTH_OUT-1:0] m_data,
    output logic        [IDX_W-1:0]          m_index,
    output logic                             m_last,
    output logic                             overflow,
    output logic        [15:0]               drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic signed [DATA_WIDTH_OUT-1:0] s_data [N];
    logic s_valid;

    logic signed [DATA_WIDTH_OUT-1:0] mem [DEPTH][N];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0] count;
    logic full, push, pop, drop;

    function automatic logic signed [DATA_WIDTH_OUT-1:0] requant(
        input logic signed [DATA_WIDTH_IN-1:0] x,
        input logic        [SHIFT_W-1:0]       s
    );
        logic signed [DATA_WIDTH_IN:0]    xe, bias, rnd;
        logic signed [DATA_WIDTH_OUT-1:0] y;
        xe   = DATA_WIDTH_IN'(x);
        bias = '0;
        rnd  = xe;
        if (int'(s) >= DATA_WIDTH_IN) begin
            // Half-up rounding of any DATA_WIDTH_IN-bit value by this many
            // bits lands on 0, and the bias would not fit the extended width.
            rnd = '0;
        end else if (s != '0) begin
            bias = (DATA_WIDTH_IN + 1)'(1) << (s - 1'b1);
            rnd  = (xe + bias) >>> s;
        end
        if (rnd > $signed({{(DATA_WIDTH_IN - DATA_WIDTH_OUT + 2){1'b0}}, {(DATA_WIDTH_OUT - 1){1'b1}}}))
            y = {1'b0, {(DATA_WIDTH_OUT - 1){1'b1}}};
        else if (rnd < $signed({{(DATA_WIDTH_IN - DATA_WIDTH_OUT + 2){1'b1}}, {(DATA_WIDTH_OUT - 1){1'b0}}}))
            y = {1'b1, {(DATA_WIDTH_OUT - 1){1'b0}}};
        else
            y = rnd[DATA_WIDTH_OUT-1:0];
`ifdef GEMM_OUT_DRAIN_RELU_EN
        if (y < 0)
            y = '0;
`endif
        return y;
    endfunction

    assign full     = (count == FULL_CNT);
    assign in_ready = !full;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push     = s_valid && (!full || pop);
    assign drop     = s_valid && !push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_valid <= 1'b0;
            for (int i = 0; i < N; i++)
                s_data[i] <= '0;
        end else begin
            s_valid <= in_valid;
            if (in_valid)
                for (int i = 0; i < N; i++)
                    s_data[i] <= requant(in_data[i], cfg_shift);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_index = '0;
        m_last  = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (count != '0)
                    state_d = SEND;
            end
            SEND: begin
                m_valid = 1'b1;
                m_data  = mem[rd_ptr][idx_q];
                m_index = idx_q;
                m_last  = (idx_q == LAST_IDX);
                if (m_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        pop   = 1'b1;
                        idx_d = '0;
                        // After the pop, a staged vector always lands, so
                        // the FIFO is empty only if it held one and none is staged.
                        if (count == (PTR_W + 1)'(1) && !s_valid)
                            state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gemm_out_drain.sv
module tb_gemm_out_drain;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic signed [15:0] in_data [N];
    logic        [3:0] cfg_shift;
    logic              in_ready;
    logic              m_valid;
    logic              m_ready;
    logic signed [7:0] m_data;
    logic        [1:0] m_index;
    logic              m_last;
    logic              overflow;
    logic       [15:0] drop_cnt;

    gemm_out_drain #(
        .N(N), .DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(8), .DEPTH(DEPTH), .SHIFT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .cfg_shift(cfg_shift), .in_ready(in_ready), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference requant: plain integer rounding division by 2^s, then clamp.
    function automatic int rq(input int x, input int s);
        int y;
        if (s == 0)
            y = x;
        else if (s >= 16)
            y = 0;
        else
            y = (x + (1 << (s - 1))) >>> s;
        if (y > 127)
            y = 127;
        if (y < -128)
            y = -128;
`ifdef GEMM_OUT_DRAIN_RELU_EN
        if (y < 0)
            y = 0;
`endif
        return y;
    endfunction

    // Reference model: queue of expected elements, vector occupancy, one staged vector.
    int expq[$];
    int got_data[$];
    int got_last[$];
    int occ = 0;
    int st_valid = 0;
    int st_vec[N];
    int m_drops = 0;
    int m_ovf = 0;
    int sent = 0;
    int stall = 0;
    int lat_arm = 0;
    int lat_cyc = -1;

    always @(negedge clk) begin
        int pop_vec;
        if (!rst) begin
            expq.delete();
            occ = 0; st_valid = 0; m_drops = 0; m_ovf = 0; sent = 0; stall = 0;
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_m_index", m_index, 0);
            chk("rst_m_last", m_last, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_drop_cnt", drop_cnt, 0);
            chk("rst_in_ready", in_ready, 1);
        end else begin
            pop_vec = 0;
            chk("in_ready", in_ready, (occ < DEPTH) ? 1 : 0);
            chk("drop_cnt", drop_cnt, m_drops);
            chk("overflow", overflow, m_ovf);
            if (lat_arm != 0 && m_valid) begin
                lat_cyc = cyc;
                lat_arm = 0;
            end
            if (m_valid) begin
                stall = 0;
                if (expq.size() == 0) begin
                    chk("valid_without_data", 1, 0);
                end else begin
                    chk("m_data", m_data, expq[0]);
                    chk("m_index", m_index, sent);
                    chk("m_last", m_last, (sent == N - 1) ? 1 : 0);
                end
                if (m_ready) begin
                    got_data.push_back(int'(m_data));
                    got_last.push_back(int'(m_last));
                    if (expq.size() > 0)
                        void'(expq.pop_front());
                    sent++;
                    if (sent == N) begin
                        sent = 0;
                        pop_vec = 1;
                    end
                end
            end else if (occ > 0) begin
                stall++;
                chk("no_stall", (stall <= 1) ? 1 : 0, 1);
            end
            if (st_valid != 0) begin
                if (occ < DEPTH || pop_vec != 0) begin
                    for (int i = 0; i < N; i++)
                        expq.push_back(st_vec[i]);
                    occ++;
                end else begin
                    m_ovf = 1;
                    if (m_drops < 65535)
                        m_drops++;
                end
            end
            occ -= pop_vec;
            st_valid = in_valid ? 1 : 0;
            if (in_valid)
                for (int i = 0; i < N; i++)
                    st_vec[i] = rq(int'(in_data[i]), int'(cfg_shift));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int a, input int b, input int c, input int d, input int s);
        in_data[0] = 16'(a);
        in_data[1] = 16'(b);
        in_data[2] = 16'(c);
        in_data[3] = 16'(d);
        cfg_shift  = 4'(s);
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
    endtask

    task automatic wait_index(input int want, input string name);
        int found;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (m_valid && int'(m_index) == want)
                found = 1;
            else
                idle(1);
        end
        chk(name, found, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0, vcnt, base, lastpos;
        int e2[N];
        rst = 1'b0;
        in_valid = 1'b0;
        m_ready = 1'b0;
        cfg_shift = '0;
        for (int i = 0; i < N; i++)
            in_data[i] = '0;
        idle(3);
        rst = 1'b1;

        chk("pin_rq_6_s2", rq(6, 2), 2);
        chk("pin_rq_7_s2", rq(7, 2), 2);
        chk("pin_rq_1000_s2", rq(1000, 2), 127);
        chk("pin_rq_m200_s0", rq(-200, 0),
`ifdef GEMM_OUT_DRAIN_RELU_EN
            0);
`else
            -128);
`endif

        // Basic pass-through, latency, index and last flag.
        m_ready = 1'b1;
        got_data.delete(); got_last.delete();
        t0 = cyc;
        lat_arm = 1;
        pulse(5, -3, 127, -128, 0);
        idle(8);
        chk("latency", lat_cyc - t0, 3);
        chk("t1_count", got_data.size(), 4);
        if (got_data.size() == 4) begin
`ifdef GEMM_OUT_DRAIN_RELU_EN
            chk("t1_e0", got_data[0], 5);
            chk("t1_e1", got_data[1], 0);
            chk("t1_e2", got_data[2], 127);
            chk("t1_e3", got_data[3], 0);
`else
            chk("t1_e0", got_data[0], 5);
            chk("t1_e1", got_data[1], -3);
            chk("t1_e2", got_data[2], 127);
            chk("t1_e3", got_data[3], -128);
`endif
            lastpos = -1;
            for (int i = 0; i < 4; i++)
                if (got_last[i] != 0)
                    lastpos = (lastpos == -1) ? i : 99;
            chk("t1_last_pos", lastpos, 3);
        end

        // Rounding shift with saturation.
        got_data.delete(); got_last.delete();
        pulse(6, 7, -6, 1000, 2);
        idle(8);
`ifdef GEMM_OUT_DRAIN_RELU_EN
        e2 = '{2, 2, 0, 127};
`else
        e2 = '{2, 2, -1, 127};
`endif
        chk("t2_count", got_data.size(), 4);
        if (got_data.size() == 4)
            for (int i = 0; i < 4; i++)
                chk($sformatf("t2_e%0d", i), got_data[i], e2[i]);

        // Back-pressure mid-vector at index 1.
        got_data.delete(); got_last.delete();
        pulse(10, 20, 30, 40, 0);
        wait_index(1, "bp_reach_idx1");
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idle(1);
            chk("bp_hold_valid", m_valid, 1);
            chk("bp_hold_index", m_index, 1);
            chk("bp_hold_data", m_data, 20);
        end
        m_ready = 1'b1;
        idle(6);
        chk("bp_count", got_data.size(), 4);
        if (got_data.size() == 4)
            for (int i = 0; i < 4; i++)
                chk($sformatf("bp_e%0d", i), got_data[i], 10 * (i + 1));

        // Overflow: six vectors against a stalled sink.
        got_data.delete(); got_last.delete();
        m_ready = 1'b0;
        for (int k = 1; k <= 6; k++)
            pulse(k * 10, k * 10 + 1, k * 10 + 2, k * 10 + 3, 0);
        idle(3);
        chk("ovf_in_ready", in_ready, 0);
        chk("ovf_drop_cnt", drop_cnt, 2);
        chk("ovf_flag", overflow, 1);
        m_ready = 1'b1;
        idle(25);
        chk("ovf_count", got_data.size(), 16);
        if (got_data.size() == 16)
            for (int j = 0; j < 16; j++)
                chk($sformatf("ovf_e%0d", j), got_data[j], (j / 4 + 1) * 10 + j % 4);

        // Push and pop on the same edge while full.
        do_reset();
        got_data.delete(); got_last.delete();
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            pulse(50 + 4 * k, 51 + 4 * k, 52 + 4 * k, 53 + 4 * k, 0);
        idle(3);
        chk("pp_full", in_ready, 0);
        m_ready = 1'b1;
        wait_index(2, "pp_reach_idx2");
        pulse(90, 91, 92, 93, 0);
        idle(1);
        chk("pp_no_drop", drop_cnt, 0);
        chk("pp_no_ovf", overflow, 0);
        chk("pp_still_full", in_ready, 0);
        idle(30);
        chk("pp_count", got_data.size(), 20);
        if (got_data.size() == 20) begin
            for (int j = 0; j < 16; j++)
                chk($sformatf("pp_e%0d", j), got_data[j], 50 + j);
            for (int j = 16; j < 20; j++)
                chk($sformatf("pp_e%0d", j), got_data[j], 74 + j);
        end

        // Reset in the middle of a vector with three queued.
        got_data.delete(); got_last.delete();
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            pulse(k + 1, k + 2, k + 3, k + 4, 0);
        idle(3);
        m_ready = 1'b1;
        wait_index(2, "rm_reach_idx2");
        m_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("rm_async_valid", m_valid, 0);
        idle(2);
        rst = 1'b1;
        m_ready = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (m_valid)
                vcnt++;
            idle(1);
        end
        chk("rm_no_output", vcnt, 0);
        chk("rm_drop_cnt", drop_cnt, 0);
        chk("rm_accepted_before", got_data.size(), 2);

        // Randomized traffic with bursts that force drops.
        for (int i = 0; i < 3000; i++) begin
            base = (i % 1000 < 300) ? 1 : 0;
            if ($urandom_range(0, 99) < ((base != 0) ? 70 : 20)) begin
                for (int e = 0; e < N; e++)
                    if ($urandom_range(0, 3) == 0)
                        in_data[e] = 16'(int'($urandom_range(0, 65535)) - 32768);
                    else
                        in_data[e] = 16'(int'($urandom_range(0, 600)) - 300);
                cfg_shift = 4'($urandom_range(0, 15));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            m_ready = ($urandom_range(0, 99) < ((base != 0) ? 30 : 90)) ? 1'b1 : 1'b0;
            idle(1);
        end
        in_valid = 1'b0;
        m_ready = 1'b1;
        idle(40);
        chk("rand_drained", expq.size(), 0);
        chk("rand_saw_drops", (m_drops > 0) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
